mixer_phase_ctrl: RTL and testbench

Measurement sequencer for the XOR phase-detector mixer. It generates the reference square wave that drives the mixer's `ref_pulse` input and runs a programmable settle window. It then integrates the mixer output (cycles where `mixer_out` is high) over a whole number of reference periods. The result is returned over a valid/ready handshake, where the ratio `xor_count/total_count` gives the phase difference between the reference and the PDM stream.

---
 rtl/mixer_phase_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mixer_phase_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_phase_ctrl.sv
// mixer_phase_ctrl
// Measurement sequencer for the XOR phase-detector mixer. It drives the
// reference square wave into the mixer, discards a programmable number of
// settle periods, and then integrates the mixer output over a whole number
// of reference periods. The phase difference is xor_count/total_count.
//
// Result handshake (valid/ready): result_valid rises when a measurement
// completes. While it is high, xor_count and total_count are held stable.
// The result is consumed on the first clock edge that sees result_valid=1
// and result_ready=1. After that edge the block is back in IDLE and
// result_valid is low.
module mixer_phase_ctrl #(
    parameter int HALF_W = 16,
    parameter int PER_W  = 8,
    parameter int CNT_W  = HALF_W + PER_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [HALF_W-1:0] half_period,
    input  logic [PER_W-1:0]  settle_periods,
    input  logic [PER_W-1:0]  num_periods,
    output logic              ref_pulse,
    input  logic              mixer_out,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [CNT_W-1:0]  xor_count,
    output logic [CNT_W-1:0]  total_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    // Configuration captured when start is sampled; zero substitutions are
    // already applied, so half_q and num_q are never zero.
    logic [HALF_W-1:0] half_q;
    logic [PER_W-1:0]  settle_q;
    logic [PER_W-1:0]  num_q;

    // Position inside the current reference period (0 .. 2H-1) and the
    // number of completed periods in the current phase (settle or measure).
    logic [HALF_W:0]   phase_q;
    logic [PER_W-1:0]  period_q;

    logic [HALF_W-1:0] half_eff;
    logic [PER_W-1:0]  num_eff;
    logic [HALF_W:0]   phase_last;
    logic              phase_wrap;
    logic [HALF_W:0]   phase_nxt;
    logic              ref_nxt;
    logic              settle_end;
    logic              measure_end;
    logic              start_ok;
    logic              running;
    logic              running_nxt;

    // Zero substitutions on the incoming configuration.
    always_comb begin
        half_eff = (half_period == '0) ? HALF_W'(1) : half_period;
        num_eff  = (num_periods == '0) ? PER_W'(1)  : num_periods;
    end

    // Phase counter arithmetic and end-of-phase detection.
    always_comb begin
        phase_last  = {half_q, 1'b0} - (HALF_W+1)'(1);
        phase_wrap  = (phase_q == phase_last);
        phase_nxt   = phase_wrap ? '0 : phase_q + (HALF_W+1)'(1);
        // High for the first H cycles of each period, low for the next H.
        ref_nxt     = (phase_nxt < {1'b0, half_q});
        settle_end  = phase_wrap && (period_q == settle_q - PER_W'(1));
        measure_end = phase_wrap && (period_q == num_q - PER_W'(1));
        start_ok    = (state == ST_IDLE) && start;
        running     = (state == ST_SETTLE) || (state == ST_MEASURE);
    end

    // Next-state logic; abort outranks the state's own transition.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (settle_periods != '0) ? ST_SETTLE : ST_MEASURE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (settle_end) begin
                    state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (measure_end) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // result_valid is always high in DONE, so ready alone
                // completes the handshake.
                if (result_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        running_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_MEASURE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the configuration on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q   <= HALF_W'(1);
            settle_q <= '0;
            num_q    <= PER_W'(1);
        end else if (start_ok) begin
            half_q   <= half_eff;
            settle_q <= settle_periods;
            num_q    <= num_eff;
        end
    end

    // Phase and period counters. The phase counter is not restarted on the
    // SETTLE-to-MEASURE hand-over, so the reference stays phase-continuous;
    // only the period count restarts for the measure window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            period_q <= '0;
        end else if (start_ok) begin
            phase_q  <= '0;
            period_q <= '0;
        end else if (running) begin
            phase_q <= phase_nxt;
            if ((state == ST_SETTLE) && settle_end) begin
                period_q <= '0;
            end else if (phase_wrap) begin
                period_q <= period_q + PER_W'(1);
            end
        end
    end

    // Reference output, straight from a flop so the mixer input never
    // glitches. The first cycle after start is the start of a high half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_pulse <= 1'b0;
        end else if (running_nxt) begin
            ref_pulse <= (state == ST_IDLE) ? 1'b1 : ref_nxt;
        end else begin
            ref_pulse <= 1'b0;
        end
    end

    // Accumulators. mixer_out is sampled on the same edge that retires the
    // ref_pulse value which produced it, so every MEASURE cycle pairs the
    // mixer output with its own reference level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_count   <= '0;
            total_count <= '0;
        end else if (start_ok) begin
            xor_count   <= '0;
            total_count <= '0;
        end else if (state == ST_MEASURE) begin
            total_count <= total_count + CNT_W'(1);
            xor_count   <= xor_count + CNT_W'(mixer_out);
        end
    end

    // Registered status outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            busy         <= (state_nxt != ST_IDLE);
            result_valid <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_mixer_phase_ctrl.sv
// tb_mixer_phase_ctrl
// Directed bench for mixer_phase_ctrl. A small mixer model forms
// mixer_out = ref_pulse ^ pdm, where pdm is chosen per run (constant 0/1,
// in phase, inverted, or delayed two cycles). Expected counts are pushed to
// a queue when a run is launched and popped when result_valid appears.
module tb_mixer_phase_ctrl;

    localparam int HALF_W = 16;
    localparam int PER_W  = 8;
    localparam int CNT_W  = HALF_W + PER_W + 1;

    // ---------------- clock / reset / signals ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              result_ready = 1'b0;
    logic [HALF_W-1:0] half_period = '0;
    logic [PER_W-1:0]  settle_periods = '0;
    logic [PER_W-1:0]  num_periods = '0;
    logic              ref_pulse;
    logic              mixer_out;
    logic              busy;
    logic              result_valid;
    logic [CNT_W-1:0]  xor_count;
    logic [CNT_W-1:0]  total_count;

    int   pdm_mode = 0;
    logic ref_d1 = 1'b0;
    logic ref_d2 = 1'b0;
    logic pdm;

    int total = 0;
    int bad   = 0;
    logic [2*CNT_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    mixer_phase_ctrl #(
        .HALF_W(HALF_W),
        .PER_W (PER_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .half_period   (half_period),
        .settle_periods(settle_periods),
        .num_periods   (num_periods),
        .ref_pulse     (ref_pulse),
        .mixer_out     (mixer_out),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .xor_count     (xor_count),
        .total_count   (total_count)
    );

    // ---------------- mixer / PDM model ----------------
    always @(posedge clk) begin
        ref_d1 <= ref_pulse;
        ref_d2 <= ref_d1;
    end

    always_comb begin
        case (pdm_mode)
            0:       pdm = 1'b0;
            1:       pdm = 1'b1;
            2:       pdm = ref_pulse;
            3:       pdm = ~ref_pulse;
            default: pdm = ref_d2;
        endcase
    end

    assign mixer_out = ref_pulse ^ pdm;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ref"},   64'(ref_pulse),    64'd0);
        check({tag, "_busy"},  64'(busy),         64'd0);
        check({tag, "_valid"}, 64'(result_valid), 64'd0);
    endtask

    // ---------------- driver ----------------
    // Launch one run, wait for the result, compare against the scoreboard,
    // optionally hold off result_ready for 'hold' cycles while pulsing start.
    task automatic run_and_check(input logic [HALF_W-1:0] h, input logic [PER_W-1:0] s,
                                 input logic [PER_W-1:0] n, input int mode,
                                 input logic [CNT_W-1:0] ex, input logic [CNT_W-1:0] et,
                                 input int exp_edges, input int hold);
        int edges;
        logic [2*CNT_W-1:0] e;
        logic [CNT_W-1:0] x_snap;
        logic [CNT_W-1:0] t_snap;
        @(negedge clk);
        half_period    = h;
        settle_periods = s;
        num_periods    = n;
        pdm_mode       = mode;
        start          = 1'b1;
        exp_q.push_back({ex, et});
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start          = 1'b0;
        half_period    = HALF_W'($urandom);
        settle_periods = PER_W'($urandom);
        num_periods    = PER_W'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        check("ref_first_cycle", 64'(ref_pulse), 64'd1);
        while (!result_valid && edges < 4000) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("valid_latency", 64'(edges), 64'(exp_edges));
        check("valid_up", 64'(result_valid), 64'd1);
        x_snap = xor_count;
        t_snap = total_count;
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 64'(result_valid), 64'd1);
            check("hold_busy", 64'(busy), 64'd1);
            check("hold_xor", 64'(xor_count), 64'(x_snap));
            check("hold_total", 64'(total_count), 64'(t_snap));
        end
        start = 1'b0;
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("xor_count", 64'(xor_count), 64'(e[2*CNT_W-1:CNT_W]));
            check("total_count", 64'(total_count), 64'(e[CNT_W-1:0]));
        end
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        check_idle("after_handshake");
        if (hold > 0) begin
            @(posedge clk);
            @(negedge clk);
            check_idle("start_ignored");
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int valid_seen;

        // reset state
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_xor", 64'(xor_count), 64'd0);
        check("reset_total", 64'(total_count), 64'd0);
        rst_n = 1'b1;

        // static PDM: mixer equals ref (PDM=0) or ~ref (PDM=1)
        run_and_check(16'd4, 8'd0, 8'd2, 0, CNT_W'(8), CNT_W'(16), 17, 0);
        run_and_check(16'd4, 8'd0, 8'd2, 1, CNT_W'(8), CNT_W'(16), 17, 0);

        // phase sweep with one settle period
        run_and_check(16'd4, 8'd1, 8'd2, 2, CNT_W'(0),  CNT_W'(16), 25, 0);
        run_and_check(16'd4, 8'd1, 8'd2, 3, CNT_W'(16), CNT_W'(16), 25, 0);
        run_and_check(16'd4, 8'd1, 8'd2, 4, CNT_W'(8),  CNT_W'(16), 25, 0);

        // zero configuration runs as H=1, N=1
        run_and_check(16'd0, 8'd0, 8'd0, 0, CNT_W'(1), CNT_W'(2), 3, 0);

        // longer, odd-sized run: H=3, S=2, N=5 with PDM=1
        run_and_check(16'd3, 8'd2, 8'd5, 1, CNT_W'(15), CNT_W'(30), 43, 0);

        // backpressure in DONE with start pulsed
        run_and_check(16'd2, 8'd0, 8'd3, 0, CNT_W'(6), CNT_W'(12), 13, 5);

        // abort mid-MEASURE
        @(negedge clk);
        half_period = 16'd4; settle_periods = 8'd0; num_periods = 8'd2;
        pdm_mode = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort");
        valid_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid) valid_seen++;
        end
        check("abort_no_valid", 64'(valid_seen), 64'd0);
        run_and_check(16'd4, 8'd0, 8'd2, 1, CNT_W'(8), CNT_W'(16), 17, 0);

        // asynchronous reset during SETTLE
        @(negedge clk);
        half_period = 16'd4; settle_periods = 8'd2; num_periods = 8'd2;
        pdm_mode = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_xor", 64'(xor_count), 64'd0);
        check("async_reset_total", 64'(total_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_valid || busy || ref_pulse) valid_seen++;
        end
        check("idle_after_reset", 64'(valid_seen), 64'd0);
        run_and_check(16'd5, 8'd1, 8'd1, 3, CNT_W'(10), CNT_W'(10), 21, 0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
